// File: rtl/pong_match_ctrl_if.sv
// Match-controller bus: game events from the playfield in, match status out to the overlay.
interface pong_match_ctrl_if;
  logic       frame_start;
  logic       start_btn;
  logic       ball_hit;
  logic       ball_miss;
  logic       game_run;
  logic       ball_serve;
  logic [7:0] score_bcd;
  logic [1:0] lives;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output frame_start, start_btn, ball_hit, ball_miss,
    input  game_run, ball_serve, score_bcd, lives, game_over, state
  );

  modport slave (
    input  frame_start, start_btn, ball_hit, ball_miss,
    output game_run, ball_serve, score_bcd, lives, game_over, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve countdown, play, miss pause and game over,
// with BCD score and lives bookkeeping driven by frame_start-timed delays.
module pong_match_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int LIVES        = 3
) (
  input logic              clk,
  input logic              reset,
  pong_match_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for first start press
  // SERVE | ball recentred, counting down SERVE_FRAMES frames
  // PLAY  | ball moving, hits score, misses cost a life
  // MISS  | pause after a miss, counting down MISS_FRAMES frames
  // OVER  | no lives left, waiting for start press
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_MISS  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_LOAD  = 8'(MISS_FRAMES);
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);

  logic [2:0] state_q;
  logic [7:0] cnt_q;
  logic [7:0] score_q;
  logic [1:0] lives_q;
  logic       serve_q;
  logic       start_prev;
  logic       start_rise;
  logic [7:0] score_inc;

  assign start_rise = bus.start_btn & ~start_prev;

  // Saturating two-digit BCD increment.
  always_comb begin
    score_inc = score_q;
    if (score_q != 8'h99) begin
      if (score_q[3:0] == 4'd9) score_inc = {score_q[7:4] + 4'd1, 4'd0};
      else                      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      score_q    <= 8'h00;
      lives_q    <= LIVES_INIT;
      serve_q    <= 1'b0;
      start_prev <= 1'b1;
    end else begin
      start_prev <= bus.start_btn;
      serve_q    <= 1'b0;
      case (state_q)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            state_q <= S_SERVE;
            score_q <= 8'h00;
            lives_q <= LIVES_INIT;
            cnt_q   <= SERVE_LOAD;
            serve_q <= 1'b1;
          end
        end
        S_SERVE: begin
          if (bus.frame_start) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (bus.ball_miss) begin
            lives_q <= lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_q <= S_OVER;
            end else begin
              state_q <= S_MISS;
              cnt_q   <= MISS_LOAD;
            end
          end else if (bus.ball_hit) begin
            score_q <= score_inc;
          end
        end
        S_MISS: begin
          if (bus.frame_start) begin
            if (cnt_q == 8'd1) begin
              state_q <= S_SERVE;
              cnt_q   <= SERVE_LOAD;
              serve_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.state      = state_q;
  assign bus.game_run   = (state_q == S_PLAY);
  assign bus.game_over  = (state_q == S_OVER);
  assign bus.ball_serve = serve_q;
  assign bus.score_bcd  = score_q;
  assign bus.lives      = lives_q;
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
- Match-level sequencer for the Pong game.
- Runs the match flow: idle, serve countdown, active play, miss pause, game over.
- Counts frames using the frame_start pulse from the VGA timing logic.
- Gates ball motion (game_run), requests ball recentre (ball_serve), and keeps score and remaining lives for the sprite/score overlay.

Parameters:
- SERVE_FRAMES, 60: frame_start pulses spent in SERVE before PLAY; legal range 1..255.
- MISS_FRAMES, 90: frame_start pulses spent in MISS before re-serve; legal range 1..255.
- LIVES, 3: lives at match start; legal range 1..3.

Ports:
- clk  input  1  25 MHz pixel clock.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  single-cycle pulse at counters (0,0).
- start_btn  input  1  level, already synchronised to clk.
- ball_hit  input  1  single-cycle pulse: ball struck paddle.
- ball_miss  input  1  single-cycle pulse: ball passed paddle.
- game_run  output  1  high only in PLAY; enables ball motion.
- ball_serve  output  1  single-cycle pulse: recentre ball.
- score_bcd  output  8  two BCD digits, {tens, ones}.
- lives  output  2  remaining lives.
- game_over  output  1  high only in OVER.
- state  output  3  current state encoding, for debug.

Behaviour:
- State encoding: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4.
- All registers use async reset. Reset values:
  - state=IDLE, score_bcd=8'h00, lives=LIVES, frame counter=0.
  - ball_serve=0, start_prev=1 (a button held through reset does not start a match).
- game_run, game_over: decoded from the state register, so asserted the cycle after the transition.
- start_rise = start_btn & ~start_prev; start_prev updates every cycle.
- IDLE:
  - start_rise -> SERVE.
  - Same edge: score=00, lives=LIVES, cnt=SERVE_FRAMES, ball_serve=1 for the next cycle only.
- SERVE:
  - Each frame_start decrements cnt.
  - frame_start with cnt==1 -> PLAY, giving exactly SERVE_FRAMES frame_starts in SERVE.
- PLAY:
  - ball_hit alone: BCD increment. Ones 9 -> 0 with carry into tens. Saturates at 99 (99 + hit stays 99).
  - ball_miss: lives decrements.
    - Prior lives==1 -> OVER, lives=0.
    - Otherwise -> MISS, cnt=MISS_FRAMES.
  - ball_hit and ball_miss in the same cycle: miss wins, score unchanged.
  - frame_start has no effect in PLAY.
- MISS:
  - Each frame_start decrements cnt.
  - frame_start with cnt==1 -> SERVE, cnt=SERVE_FRAMES, ball_serve pulse.
- OVER:
  - Score and lives hold.
  - start_rise -> SERVE with the same actions as from IDLE.
- Ignored events:
  - ball_hit and ball_miss outside PLAY.
  - start_rise in SERVE, PLAY and MISS.
  - frame_start in IDLE and OVER.
- frame_start coincident with a state-entry cycle is counted only by the new state's rule on the following cycles; the entry cycle loads cnt and does not decrement.
- ball_serve is registered and high for exactly one cycle, the first cycle state==SERVE.
- Reset asserted mid-match: all outputs return immediately (asynchronously) to reset values. After deassertion, the block needs a fresh start_btn rising edge.

Test Plan:
- Reset then start_btn 0->1 at cycle N -> state=1 and ball_serve=1 at N+1, ball_serve=0 at N+2, score=8'h00, lives=3.
- SERVE_FRAMES=3; pulse frame_start 3 times -> state=2 and game_run=1 the cycle after the third pulse, not before.
- In PLAY, 10 ball_hit pulses -> score_bcd=8'h10; drive to 99, one more hit -> stays 8'h99. Simultaneous hit+miss -> score unchanged, lives 3->2, state=3.
- Three misses, each followed by the MISS and SERVE countdowns -> lives 3->2->1->0. After the third miss state=4, game_over=1. start_btn edge -> SERVE, score=00, lives=3.
- start_btn held high across reset deassertion -> state stays 0. Hit/miss pulses in IDLE -> score and lives unchanged.
- Assert reset mid-PLAY with score=8'h25 -> outputs immediately 0/00/3/IDLE, game_run=0, with no clock edge required.
